borus_exec_ctrl: RTL and testbench
==================================

Name: borus_exec_ctrl

Overview:
- Execution and program-load controller for the Borus CPU core.
- Receives a byte-wide command stream from a host (debug/UART bridge) and writes program bytes into the writable program memory.
- Sequences the core through reset, run, single-step and stop by driving its reset and a cycle-enable.
- Sole writer of program memory; the CPU fetch port stays read-only.

Parameters:
- ADDR_W, 8, program memory address width; addresses wrap modulo 2^ADDR_W.
- RST_CYCLES, 2, number of cycles cpu_rst is held for a RESET command; minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- host_data  in  8  command/data byte from host
- host_valid  in  1  host_data valid
- host_ready  out  1  controller accepts byte; a transfer occurs when valid && ready on a rising clk edge
- mem_we  out  1  program memory write strobe, one cycle per byte
- mem_addr  out  ADDR_W  program memory write address
- mem_wdata  out  8  program memory write data
- cpu_rst  out  1  reset to CPU core
- cpu_en  out  1  CPU cycle enable; the core advances only on cycles where it is 1
- cpu_halted  in  1  CPU halted flag (HLT executed)
- running  out  1  free-run mode active
- loading  out  1  load transfer in progress
- err  out  1  sticky protocol error

Behaviour:
- Reset values: host_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, cpu_en=0, running=0, loading=0, err=0. State = RSTHOLD with the counter loaded to RST_CYCLES.
- States: IDLE, GET_ADDR, GET_LEN, GET_DATA, RSTHOLD, plus CSUM when the optional feature is enabled.
- host_ready: 1 in IDLE, GET_ADDR, GET_LEN, GET_DATA and CSUM; 0 in RSTHOLD.
- RSTHOLD:
  - cpu_rst=1 and cpu_en=0.
  - The counter decrements each cycle; when it reaches 0, go to IDLE with cpu_rst=0 on the next cycle.
- IDLE commands (each byte consumed on handshake; effects start the cycle after acceptance):
  - 0xA0 LOAD: running:=0, cpu_en:=0, cpu_rst:=1, loading:=1, go to GET_ADDR.
  - 0xB0 RUN: running:=1, which drives cpu_en=1 every cycle while running.
  - 0xB1 STEP: cpu_en=1 for exactly one cycle. Ignored (no error) if running=1.
  - 0xB2 STOP: running:=0, so cpu_en=0 from the next cycle.
  - 0xB3 RESET: running:=0, err:=0, enter RSTHOLD for RST_CYCLES cycles.
  - Any other byte: err:=1; byte dropped, stay in IDLE.
- Auto-stop: while running=1, cpu_halted=1 clears running on the next edge. RUN or STEP while cpu_halted=1 sets no cpu_en pulse and no error.
- GET_ADDR: the byte becomes the start address. mem_addr := byte, zero-extended or truncated to ADDR_W. Go to GET_LEN.
- GET_LEN:
  - Byte = count N.
  - N=0 ends the load immediately: loading:=0, cpu_rst:=0, go to IDLE.
  - Otherwise go to GET_DATA.
- GET_DATA:
  - Each accepted byte gives mem_we=1 for exactly one cycle, with mem_wdata=byte at the current mem_addr.
  - mem_addr increments after each write, wrapping 2^ADDR_W-1 -> 0.
  - Back-to-back bytes produce back-to-back writes.
  - After the Nth byte, the load completes: loading:=0 and cpu_rst:=0 the cycle after the last write, then IDLE. The CPU stays stopped (running=0) and starts from PC 0.
- host_valid low: the state is held indefinitely; no timeout.
- Async rst mid-load: immediate return to reset values. Bytes already written remain in memory.

Optional Feature:
- Macro: BORUS_LOAD_CSUM_EN.
- Enabled:
  - After the Nth data byte, go to CSUM and expect one byte equal to the 8-bit two's-complement sum of address, N and all data bytes, with the sum computed mod 256 and the CSUM byte itself included making the total 0.
  - On mismatch, err:=1. Either way, then complete the load as above.
  - A length-0 load also passes through CSUM.
- Disabled: no CSUM state; the load completes after the last data byte, and there is no checksum logic.

Test Plan:
- Reset release: rst 1->0 -> cpu_rst stays 1 for 2 cycles then 0; host_ready rises with cpu_rst fall; all other outputs 0.
- LOAD A0,10,03,11,22,33 -> mem_we pulses at addr 0x10/0x11/0x12 with data 11/22/33; cpu_rst=1 throughout; loading falls and cpu_rst=0 one cycle after the last write.
- Wrap: LOAD A0,FF,02,AA,BB -> writes 0xFF<-AA, 0x00<-BB; LOAD A0,40,00 -> no mem_we, loading ends.
- RUN, then cpu_halted forced high 5 cycles later -> cpu_en high 5 cycles, running clears on the next edge; STEP -> one cpu_en cycle only after releasing cpu_halted.
- Bad byte 0x55 in IDLE -> err=1, state unchanged; RESET (B3) -> err=0, cpu_rst pulse of 2 cycles.
- (CSUM_EN) LOAD A0,00,01,05 with checksum FA -> err stays 0; the same sequence with checksum 00 -> err=1, load still completes.

Source files
------------

// File: rtl/borus_exec_ctrl.sv
// rtl/borus_exec_ctrl.sv - Borus program-load and execution controller
// Optional load checksum byte is enabled by defining BORUS_LOAD_CSUM_EN.
module borus_exec_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        host_data,
    input  logic              host_valid,
    output logic              host_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst,
    output logic              cpu_en,
    input  logic              cpu_halted,
    output logic              running,
    output logic              loading,
    output logic              err
);

    localparam int CNT_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_LEN,
        S_GET_DATA,
        S_RSTHOLD
`ifdef BORUS_LOAD_CSUM_EN
        , S_CSUM
`endif
    } state_t;

`ifdef BORUS_LOAD_CSUM_EN
    localparam state_t LOAD_END = S_CSUM;
    logic [7:0] csum;
`else
    localparam state_t LOAD_END = S_IDLE;
    logic       finish_q;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       remaining;
    logic             step_q;
    logic             accept;
    logic             cnt_done;

    assign host_ready = (state != S_RSTHOLD);
    assign accept     = host_valid && host_ready;
    assign cpu_en     = running || step_q;
    assign cnt_done   = (cnt <= CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RSTHOLD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RSTHOLD:  if (cnt_done) state_nxt = S_IDLE;
            S_IDLE: begin
                if (accept && host_data == 8'hA0) state_nxt = S_GET_ADDR;
                if (accept && host_data == 8'hB3) state_nxt = S_RSTHOLD;
            end
            S_GET_ADDR: if (accept) state_nxt = S_GET_LEN;
            S_GET_LEN:  if (accept) state_nxt = (host_data == 8'd0) ? LOAD_END : S_GET_DATA;
            S_GET_DATA: if (accept && remaining == 8'd1) state_nxt = LOAD_END;
`ifdef BORUS_LOAD_CSUM_EN
            S_CSUM:     if (accept) state_nxt = S_IDLE;
`endif
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            cpu_rst   <= 1'b1;
            running   <= 1'b0;
            loading   <= 1'b0;
            err       <= 1'b0;
            step_q    <= 1'b0;
            cnt       <= CNT_W'(RST_CYCLES);
            remaining <= 8'd0;
`ifdef BORUS_LOAD_CSUM_EN
            csum      <= 8'd0;
`else
            finish_q  <= 1'b0;
`endif
        end else begin
            mem_we <= 1'b0;
            step_q <= 1'b0;
            if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
            if (running && cpu_halted) running <= 1'b0;
`ifndef BORUS_LOAD_CSUM_EN
            // Load ends the cycle after the final write strobe, not with it.
            finish_q <= 1'b0;
            if (finish_q) begin
                loading <= 1'b0;
                cpu_rst <= 1'b0;
            end
`endif
            case (state)
                S_RSTHOLD: begin
                    if (cnt_done) cpu_rst <= 1'b0;
                    else          cnt     <= cnt - CNT_W'(1);
                end
                S_IDLE: if (accept) begin
                    case (host_data)
                        8'hA0: begin
                            running <= 1'b0;
                            cpu_rst <= 1'b1;
                            loading <= 1'b1;
                        end
                        8'hB0: if (!cpu_halted) running <= 1'b1;
                        8'hB1: if (!running && !cpu_halted) step_q <= 1'b1;
                        8'hB2: running <= 1'b0;
                        8'hB3: begin
                            running <= 1'b0;
                            err     <= 1'b0;
                            cpu_rst <= 1'b1;
                            cnt     <= CNT_W'(RST_CYCLES);
                        end
                        default: err <= 1'b1;
                    endcase
                end
                S_GET_ADDR: if (accept) begin
                    mem_addr <= ADDR_W'(host_data);
`ifdef BORUS_LOAD_CSUM_EN
                    csum     <= host_data;
`endif
                end
                S_GET_LEN: if (accept) begin
                    remaining <= host_data;
`ifdef BORUS_LOAD_CSUM_EN
                    csum      <= csum + host_data;
`else
                    if (host_data == 8'd0) begin
                        loading <= 1'b0;
                        cpu_rst <= 1'b0;
                    end
`endif
                end
                S_GET_DATA: if (accept) begin
                    mem_we    <= 1'b1;
                    mem_wdata <= host_data;
                    remaining <= remaining - 8'd1;
`ifdef BORUS_LOAD_CSUM_EN
                    csum      <= csum + host_data;
`else
                    if (remaining == 8'd1) finish_q <= 1'b1;
`endif
                end
`ifdef BORUS_LOAD_CSUM_EN
                S_CSUM: if (accept) begin
                    if (csum + host_data != 8'd0) err <= 1'b1;
                    loading <= 1'b0;
                    cpu_rst <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_borus_exec_ctrl.sv
// tb/tb_borus_exec_ctrl.sv - self-checking bench for borus_exec_ctrl
module tb_borus_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] host_data = 8'd0;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_rst;
    logic       cpu_en;
    logic       cpu_halted = 1'b0;
    logic       running;
    logic       loading;
    logic       err;

    always #5 clk = ~clk;

    borus_exec_ctrl #(.ADDR_W(8), .RST_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .cpu_en(cpu_en), .cpu_halted(cpu_halted),
        .running(running), .loading(loading), .err(err)
    );

    typedef struct {
        logic [7:0] b;
        logic       halted;
        logic       exp_run;
        logic       exp_en;
        logic       exp_err;
        logic       exp_crst;
    } vec_t;

    int         total = 0;
    int         bad = 0;
    int         nwrites = 0;
    logic [7:0] obs_mem [256];
    logic [7:0] exp_mem [256];
    logic [7:0] dat [16];
    logic       exp_err = 1'b0;
    logic       exp_run = 1'b0;
    vec_t       vecs [8];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            obs_mem[mem_addr] = mem_wdata;
            nwrites++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        while (host_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("ready_timeout", {31'd0, host_ready}, 32'd1);
        host_data  = b;
        host_valid = 1'b1;
        @(posedge clk);
        #1 host_valid = 1'b0;
    endtask

    task automatic chk_mem(input string name);
        int m = 0;
        for (int i = 0; i < 256; i++) if (obs_mem[i] !== exp_mem[i]) m++;
        chk(name, m, 0);
    endtask

    task automatic do_load(input logic [7:0] a, input int n, input logic csum_good);
        logic [7:0] s;
        logic [7:0] idx;
        send(8'hA0);
        chk("load_start", {loading, cpu_rst, running}, 3'b110);
        send(a);
        send(n[7:0]);
        s = a + n[7:0];
        for (int i = 0; i < n; i++) begin
            send(dat[i]);
            idx = a + i[7:0];
            exp_mem[idx] = dat[i];
            s = s + dat[i];
        end
`ifdef BORUS_LOAD_CSUM_EN
        if (csum_good) send(8'd0 - s);
        else begin
            send(~(8'd0 - s));
            exp_err = 1'b1;
        end
`else
        if (!csum_good) exp_err = exp_err;
`endif
        exp_run = 1'b0;
        @(posedge clk);
        #1;
        chk("load_end", {loading, cpu_rst, running}, 3'b000);
        chk("load_err", {31'd0, err}, {31'd0, exp_err});
    endtask

    initial begin
        int         n;
        int         nw;
        int         op;
        logic [7:0] b;

        for (int i = 0; i < 256; i++) begin
            obs_mem[i] = 8'd0;
            exp_mem[i] = 8'd0;
        end

        // reset release
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_outs", {host_ready, mem_we, cpu_en, running, loading, err, cpu_rst}, 7'b0000001);
        chk("reset_addr", {mem_addr, mem_wdata}, 16'd0);
        @(posedge clk); #1;
        chk("rsthold_c1", {cpu_rst, host_ready}, 2'b10);
        @(posedge clk); #1;
        chk("rsthold_c2", {cpu_rst, host_ready, cpu_en, running, loading, err, mem_we}, 7'b0100000);

        // basic load with timing of the final write
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33;
`ifndef BORUS_LOAD_CSUM_EN
        send(8'hA0);
        chk("load10_start", {loading, cpu_rst, running}, 3'b110);
        send(8'h10);
        send(8'h03);
        send(8'h11);
        send(8'h22);
        chk("load10_w2", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'h11, 8'h22});
        send(8'h33);
        chk("load10_w3", {mem_we, mem_addr, mem_wdata, loading, cpu_rst}, {1'b1, 8'h12, 8'h33, 2'b11});
        @(posedge clk); #1;
        chk("load10_end", {mem_we, loading, cpu_rst}, 3'b000);
        exp_mem[8'h10] = 8'h11; exp_mem[8'h11] = 8'h22; exp_mem[8'h12] = 8'h33;
`else
        do_load(8'h10, 3, 1'b1);
`endif
        chk_mem("mem_load10");

        // address wrap and zero-length load
        dat[0] = 8'hAA; dat[1] = 8'hBB;
        do_load(8'hFF, 2, 1'b1);
        chk("wrap_ff", {24'd0, obs_mem[8'hFF]}, 32'hAA);
        chk("wrap_00", {24'd0, obs_mem[8'h00]}, 32'hBB);
        nw = nwrites;
        do_load(8'h40, 0, 1'b1);
        chk("len0_no_write", nwrites - nw, 0);
        chk_mem("mem_wrap");

        // run, auto-stop on halt, step gating
        send(8'hB0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (cpu_en) n++;
        end
        cpu_halted = 1'b1;
        @(posedge clk); #1;
        chk("halt_stop", {running, cpu_en}, 2'b00);
        chk("run_cycles", n, 5);
        send(8'hB1);
        chk("step_halted", {31'd0, cpu_en}, 32'd0);
        cpu_halted = 1'b0;
        send(8'hB1);
        chk("step_pulse", {running, cpu_en}, 2'b01);
        @(posedge clk); #1;
        chk("step_one", {31'd0, cpu_en}, 32'd0);

        // command table
        vecs[0] = '{8'hB0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hB1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hB2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'hB1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'hB0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'hB1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{8'hB3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            cpu_halted = vecs[i].halted;
            send(vecs[i].b);
            chk($sformatf("vec%0d", i), {running, cpu_en, err, cpu_rst},
                {vecs[i].exp_run, vecs[i].exp_en, vecs[i].exp_err, vecs[i].exp_crst});
        end
        cpu_halted = 1'b0;
        @(posedge clk); #1;
        chk("reset_cmd_c2", {cpu_rst, host_ready}, 2'b10);
        @(posedge clk); #1;
        chk("reset_cmd_done", {cpu_rst, host_ready}, 2'b01);
        exp_err = 1'b0;
        exp_run = 1'b0;

`ifdef BORUS_LOAD_CSUM_EN
        dat[0] = 8'h05;
        do_load(8'h00, 1, 1'b1);
        do_load(8'h00, 1, 1'b0);
        chk_mem("mem_csum");
`endif

        // randomized commands against the reference model
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 6);
            case (op)
                0, 1, 2: begin
                    n = $urandom_range(0, 6);
                    for (int i = 0; i < n; i++) dat[i] = 8'($urandom);
                    do_load(8'($urandom), n, 1'($urandom_range(0, 1)));
                    chk_mem("rand_mem");
                end
                3: begin
                    send(8'hB0);
                    exp_run = 1'b1;
                end
                4: begin
                    send(8'hB2);
                    exp_run = 1'b0;
                end
                5: begin
                    do b = 8'($urandom);
                    while (b inside {8'hA0, 8'hB0, 8'hB1, 8'hB2, 8'hB3});
                    send(b);
                    exp_err = 1'b1;
                end
                default: begin
                    send(8'hB3);
                    exp_err = 1'b0;
                    exp_run = 1'b0;
                    chk("rand_reset_rst", {31'd0, cpu_rst}, 32'd1);
                end
            endcase
            chk("rand_state", {running, cpu_en, err}, {exp_run, exp_run, exp_err});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
